irq_gateway: RTL and testbench

- Interrupt conditioning stage directly upstream of the trivial PLIC.
- Each external interrupt line passes through a synchronizer, polarity inversion and a level/edge selector before the PLIC samples it.
- irq_out[n] drives PLIC irq(n+1).
- Edge-mode lines are latched and cleared by software through a small AXI4-Lite register block, so short pulses from async peripherals are never lost.

---
 rtl/irq_gateway.sv | 277 +++++++++++++++++++++++++++
 tb/tb_irq_gateway.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_gateway.sv
// -----------------------------------------------------------------------------
// irq_gateway
//
// Interrupt conditioning stage that sits directly in front of the PLIC. Each
// external line passes through a synchronizer, an optional glitch filter, a
// polarity inverter and a level/edge selector. Edge-mode lines are latched in
// EDGER and cleared by software (write-one-to-clear) over AXI4-Lite. irq_out[n]
// drives PLIC source n+1.
//
// Optional feature macro: IRQ_GATEWAY_FILTER_EN
//   When defined, each line gets an 8-bit stability counter after the
//   synchronizer. The line only changes once the synchronized input has
//   differed from the filtered value for FILTER_CYCLES consecutive cycles.
//
// Register map (bits >= NUM_IRQ read 0 and ignore writes):
//   0x00 MODER  RW    1 = edge mode, 0 = level mode
//   0x04 POLR   RW    1 = active-low input
//   0x08 EDGER  W1C   latched edges
//   0x0C RAWR   RO    synchronized, polarity-corrected lines
//
// Ports:
//   ACLK, ARESET       clock, synchronous active-high reset
//   irq_in             raw asynchronous interrupt lines
//   irq_out            conditioned, registered interrupts (active high)
//   AW*/W*/B*          AXI4-Lite write channels (WSTRB ignored, BRESP = OKAY)
//   AR*/R*             AXI4-Lite read channels (RRESP = OKAY)
// -----------------------------------------------------------------------------
module irq_gateway #(
    parameter int NUM_IRQ       = 32,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic               ACLK,
    input  logic               ARESET,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic [NUM_IRQ-1:0] irq_out,
    input  logic               AWVALID,
    output logic               AWREADY,
    input  logic [7:0]         AWADDR,
    input  logic               WVALID,
    output logic               WREADY,
    input  logic [31:0]        WDATA,
    input  logic [3:0]         WSTRB,
    output logic               BVALID,
    input  logic               BREADY,
    output logic [1:0]         BRESP,
    input  logic               ARVALID,
    output logic               ARREADY,
    input  logic [7:0]         ARADDR,
    output logic               RVALID,
    input  logic               RREADY,
    output logic [31:0]        RDATA,
    output logic [1:0]         RRESP
);

    localparam logic [7:0] ADDR_MODER = 8'h00;
    localparam logic [7:0] ADDR_POLR  = 8'h04;
    localparam logic [7:0] ADDR_EDGER = 8'h08;
    localparam logic [7:0] ADDR_RAWR  = 8'h0C;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [NUM_IRQ-1:0] prev_q;
    logic [NUM_IRQ-1:0] moder_q;
    logic [NUM_IRQ-1:0] polr_q;
    logic [NUM_IRQ-1:0] edger_q;
    logic [7:0]         awaddr_q;
    logic [31:0]        rdata_q;

    wr_state_t wr_state, wr_next;
    rd_state_t rd_state, rd_next;

    logic aw_fire;
    logic w_fire;
    logic ar_fire;

    logic [NUM_IRQ-1:0] sync_out;
    logic [NUM_IRQ-1:0] cond;
    logic [NUM_IRQ-1:0] s;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] clear_mask;
    logic [NUM_IRQ-1:0] edger_next;
    logic [31:0]        rd_word;

    // WSTRB is ignored (full-word writes only); upper WDATA bits are unused
    // when NUM_IRQ < 32.
    logic unused_ok;
    assign unused_ok = ^{WSTRB, WDATA, 8'(FILTER_CYCLES)};

    assign sync_out = sync_q[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // Optional glitch filter
    // -------------------------------------------------------------------------
`ifdef IRQ_GATEWAY_FILTER_EN
    localparam logic [7:0] FILT_LAST = 8'(FILTER_CYCLES - 1);

    logic [7:0]         filt_cnt [NUM_IRQ];
    logic [NUM_IRQ-1:0] filt_q;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            filt_q <= '0;
            for (int n = 0; n < NUM_IRQ; n++) filt_cnt[n] <= 8'd0;
        end else begin
            for (int n = 0; n < NUM_IRQ; n++) begin
                if (sync_out[n] != filt_q[n]) begin
                    // The FILTER_CYCLES-th consecutive differing cycle commits.
                    if (filt_cnt[n] == FILT_LAST) begin
                        filt_q[n]   <= sync_out[n];
                        filt_cnt[n] <= 8'd0;
                    end else begin
                        filt_cnt[n] <= filt_cnt[n] + 8'd1;
                    end
                end else begin
                    filt_cnt[n] <= 8'd0;
                end
            end
        end
    end

    assign cond = filt_q;
`else
    assign cond = sync_out;
`endif

    // -------------------------------------------------------------------------
    // Per-line datapath
    // -------------------------------------------------------------------------
    assign s          = cond ^ polr_q;
    assign rise       = s & ~prev_q;
    assign clear_mask = (w_fire && awaddr_q == ADDR_EDGER) ? WDATA[NUM_IRQ-1:0] : '0;
    // Clear is applied before the new rise is OR'd in, so a coincident edge wins.
    assign edger_next = (edger_q & ~clear_mask) | (rise & moder_q);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours (the sync chain depends on it).
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev_q   <= '0;
            moder_q  <= '0;
            polr_q   <= '0;
            edger_q  <= '0;
            irq_out  <= '0;
            awaddr_q <= 8'h00;
        end else begin
            sync_q[0] <= irq_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q  <= s;
            edger_q <= edger_next;
            // Mode select uses the MODER value in force before any write this cycle.
            irq_out <= (moder_q & edger_next) | (~moder_q & s);

            if (aw_fire) awaddr_q <= AWADDR;

            if (w_fire) begin
                case (awaddr_q)
                    ADDR_MODER: moder_q <= WDATA[NUM_IRQ-1:0];
                    ADDR_POLR:  polr_q  <= WDATA[NUM_IRQ-1:0];
                    default:    ;
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // Write channel FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge ACLK) begin
        if (ARESET) wr_state <= W_IDLE;
        else        wr_state <= wr_next;
    end

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statement can leave a value held (no latches).
    always_comb begin
        wr_next = wr_state;
        AWREADY = 1'b0;
        WREADY  = 1'b0;
        BVALID  = 1'b0;
        aw_fire = 1'b0;
        w_fire  = 1'b0;
        case (wr_state)
            W_IDLE: begin
                AWREADY = 1'b1;
                if (AWVALID) begin
                    aw_fire = 1'b1;
                    wr_next = W_DATA;
                end
            end
            W_DATA: begin
                WREADY = 1'b1;
                if (WVALID) begin
                    w_fire  = 1'b1;
                    wr_next = W_RESP;
                end
            end
            W_RESP: begin
                BVALID = 1'b1;
                if (BREADY) wr_next = W_IDLE;
            end
            default: wr_next = W_IDLE;
        endcase
        // Handshakes are suppressed while reset is asserted, so an in-flight
        // response disappears immediately rather than one edge later.
        if (ARESET) begin
            AWREADY = 1'b0;
            WREADY  = 1'b0;
            BVALID  = 1'b0;
            aw_fire = 1'b0;
            w_fire  = 1'b0;
        end
    end

    assign BRESP = 2'b00;

    // -------------------------------------------------------------------------
    // Read channel FSM
    // -------------------------------------------------------------------------
    always_comb begin
        rd_word = '0;
        case (ARADDR)
            ADDR_MODER: rd_word[NUM_IRQ-1:0] = moder_q;
            ADDR_POLR:  rd_word[NUM_IRQ-1:0] = polr_q;
            ADDR_EDGER: rd_word[NUM_IRQ-1:0] = edger_q;
            ADDR_RAWR:  rd_word[NUM_IRQ-1:0] = s;
            default:    rd_word = '0;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rd_state <= R_IDLE;
            rdata_q  <= '0;
        end else begin
            rd_state <= rd_next;
            // EDGER is sampled before a coincident W1C takes effect.
            if (ar_fire) rdata_q <= rd_word;
        end
    end

    always_comb begin
        rd_next = rd_state;
        ARREADY = 1'b0;
        RVALID  = 1'b0;
        ar_fire = 1'b0;
        case (rd_state)
            R_IDLE: begin
                ARREADY = 1'b1;
                if (ARVALID) begin
                    ar_fire = 1'b1;
                    rd_next = R_DATA;
                end
            end
            R_DATA: begin
                RVALID = 1'b1;
                if (RREADY) rd_next = R_IDLE;
            end
            default: rd_next = R_IDLE;
        endcase
        if (ARESET) begin
            ARREADY = 1'b0;
            RVALID  = 1'b0;
            ar_fire = 1'b0;
        end
    end

    assign RDATA = rdata_q;
    assign RRESP = 2'b00;

endmodule

// File: tb/tb_irq_gateway.sv
// -----------------------------------------------------------------------------
// tb_irq_gateway
//
// Directed testbench for irq_gateway with default parameters. Inputs are driven
// 1 ns after the rising edge and outputs are sampled at that same point.
// Build with IRQ_GATEWAY_FILTER_EN defined to exercise the glitch filter.
// -----------------------------------------------------------------------------
module tb_irq_gateway;

    localparam int SYNC_STAGES   = 2;
    localparam int FILTER_CYCLES = 4;
`ifdef IRQ_GATEWAY_FILTER_EN
    localparam int LAT = SYNC_STAGES + FILTER_CYCLES + 1;
    localparam int PW  = FILTER_CYCLES;
`else
    localparam int LAT = SYNC_STAGES + 1;
    localparam int PW  = 1;
`endif
    localparam int TMO = 20;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [31:0] irq_in;
    logic [31:0] irq_out;
    logic        AWVALID, AWREADY;
    logic [7:0]  AWADDR;
    logic        WVALID, WREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        BVALID, BREADY;
    logic [1:0]  BRESP;
    logic        ARVALID, ARREADY;
    logic [7:0]  ARADDR;
    logic        RVALID, RREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;

    int checks = 0;
    int errors = 0;

    irq_gateway #(
        .NUM_IRQ      (32),
        .SYNC_STAGES  (SYNC_STAGES),
        .FILTER_CYCLES(FILTER_CYCLES)
    ) dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .irq_in (irq_in),
        .irq_out(irq_out),
        .AWVALID(AWVALID),
        .AWREADY(AWREADY),
        .AWADDR (AWADDR),
        .WVALID (WVALID),
        .WREADY (WREADY),
        .WDATA  (WDATA),
        .WSTRB  (WSTRB),
        .BVALID (BVALID),
        .BREADY (BREADY),
        .BRESP  (BRESP),
        .ARVALID(ARVALID),
        .ARREADY(ARREADY),
        .ARADDR (ARADDR),
        .RVALID (RVALID),
        .RREADY (RREADY),
        .RDATA  (RDATA),
        .RRESP  (RRESP)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d);
        int n;
        AWADDR = a; AWVALID = 1'b1;
        n = 0;
        while (!AWREADY && n < TMO) begin tick(); n++; end
        if (n >= TMO) check("aw_timeout", 32'd1, 32'd0);
        tick();
        AWVALID = 1'b0;
        WDATA = d; WVALID = 1'b1;
        n = 0;
        while (!WREADY && n < TMO) begin tick(); n++; end
        if (n >= TMO) check("w_timeout", 32'd1, 32'd0);
        tick();
        WVALID = 1'b0;
        BREADY = 1'b1;
        n = 0;
        while (!BVALID && n < TMO) begin tick(); n++; end
        if (n >= TMO) check("b_timeout", 32'd1, 32'd0);
        tick();
        BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d);
        int n;
        ARADDR = a; ARVALID = 1'b1;
        n = 0;
        while (!ARREADY && n < TMO) begin tick(); n++; end
        if (n >= TMO) check("ar_timeout", 32'd1, 32'd0);
        tick();
        ARVALID = 1'b0;
        RREADY = 1'b1;
        n = 0;
        while (!RVALID && n < TMO) begin tick(); n++; end
        if (n >= TMO) check("r_timeout", 32'd1, 32'd0);
        d = RDATA;
        tick();
        RREADY = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;

        ARESET = 1'b1; irq_in = '0;
        AWVALID = 1'b0; AWADDR = '0; WVALID = 1'b0; WDATA = '0; WSTRB = 4'hF;
        BREADY = 1'b0; ARVALID = 1'b0; ARADDR = '0; RREADY = 1'b0;
        repeat (3) tick();
        check("rst_bvalid", {31'd0, BVALID}, 32'd0);
        check("rst_rvalid", {31'd0, RVALID}, 32'd0);
        ARESET = 1'b0;
        tick();
        check("rst_irq_out", irq_out, 32'd0);
        check("rst_awready", {31'd0, AWREADY}, 32'd1);
        check("rst_arready", {31'd0, ARREADY}, 32'd1);
        check("rst_bresp", {30'd0, BRESP}, 32'd0);
        axi_read(8'h08, rd);
        check("rst_edger", rd, 32'd0);

        // ---- Level mode, line 0 ----
        irq_in[0] = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            check("lvl_rise", {31'd0, irq_out[0]}, (k == LAT) ? 32'd1 : 32'd0);
        end
        axi_read(8'h0C, rd);
        check("lvl_rawr", rd, 32'h1);
        repeat (2) tick();
        irq_in[0] = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            check("lvl_fall", {31'd0, irq_out[0]}, (k == LAT) ? 32'd0 : 32'd1);
        end

        // ---- Edge mode, short pulse on line 1 ----
        axi_write(8'h00, 32'h2);
        irq_in[1] = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            if (k == PW) irq_in[1] = 1'b0;
            check("edge_rise", {31'd0, irq_out[1]}, (k == LAT) ? 32'd1 : 32'd0);
        end
        repeat (5) tick();
        check("edge_hold", {31'd0, irq_out[1]}, 32'd1);
        axi_read(8'h08, rd);
        check("edge_edger", rd, 32'h2);
        axi_write(8'h08, 32'h2);
        check("edge_clear", {31'd0, irq_out[1]}, 32'd0);
        axi_read(8'h08, rd);
        check("edge_edger_clr", rd, 32'h0);

        // ---- Rise coincident with W1C: set wins ----
        irq_in[1] = 1'b1;
        repeat (PW) tick();
        irq_in[1] = 1'b0;
        repeat (LAT + 3) tick();
        check("sim_pre", {31'd0, irq_out[1]}, 32'd1);
        irq_in[1] = 1'b1;
        AWADDR = 8'h08; AWVALID = 1'b1;
        WDATA = 32'h2;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            if (k == 1) AWVALID = 1'b0;
            if (k == PW) irq_in[1] = 1'b0;
            if (k == LAT - 1) WVALID = 1'b1;
        end
        WVALID = 1'b0;
        check("sim_irq_out", {31'd0, irq_out[1]}, 32'd1);
        check("sim_bvalid", {31'd0, BVALID}, 32'd1);
        BREADY = 1'b1; tick(); BREADY = 1'b0;
        axi_read(8'h08, rd);
        check("sim_edger", rd, 32'h2);
        axi_write(8'h08, 32'h2);
        check("sim_clear", {31'd0, irq_out[1]}, 32'd0);

        // ---- Active-low polarity, line 2 ----
        axi_write(8'h04, 32'h4);
        check("pol_idle_high", {31'd0, irq_out[2]}, 32'd1);
        irq_in[2] = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            check("pol_fall", {31'd0, irq_out[2]}, (k == LAT) ? 32'd0 : 32'd1);
        end

        // ---- AXI: stalled write response ----
        AWADDR = 8'h00; AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        check("axi_aw_busy", {31'd0, AWREADY}, 32'd0);
        WDATA = 32'hFFFF_FFFF; WVALID = 1'b1;
        tick();
        WVALID = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("axi_bvalid_hold", {31'd0, BVALID}, 32'd1);
            check("axi_awready_low", {31'd0, AWREADY}, 32'd0);
            tick();
        end
        check("axi_bresp", {30'd0, BRESP}, 32'd0);
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        check("axi_bvalid_done", {31'd0, BVALID}, 32'd0);
        check("axi_awready_back", {31'd0, AWREADY}, 32'd1);
        axi_read(8'h00, rd);
        check("axi_rd_moder", rd, 32'hFFFF_FFFF);
        axi_read(8'h04, rd);
        check("axi_rd_polr", rd, 32'h4);
        axi_read(8'h40, rd);
        check("axi_rd_unmapped", rd, 32'h0);

`ifdef IRQ_GATEWAY_FILTER_EN
        // ---- Glitch filter: pulse one cycle short of the window ----
        irq_in[3] = 1'b1;
        repeat (FILTER_CYCLES - 1) tick();
        irq_in[3] = 1'b0;
        repeat (LAT + 6) tick();
        check("filt_suppress", {31'd0, irq_out[3]}, 32'd0);
        axi_read(8'h08, rd);
        check("filt_edger", rd & 32'h8, 32'h0);
`endif

        // ---- Reset during write response ----
        AWADDR = 8'h04; AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        WDATA = 32'h0; WVALID = 1'b1;
        tick();
        WVALID = 1'b0;
        check("rst_resp_pre", {31'd0, BVALID}, 32'd1);
        ARESET = 1'b1;
        #1;
        check("rst_resp_bvalid", {31'd0, BVALID}, 32'd0);
        tick();
        check("rst_resp_irq_out", irq_out, 32'd0);
        ARESET = 1'b0;
        #1;
        check("rst_resp_awready", {31'd0, AWREADY}, 32'd1);
        tick();
        check("rst_resp_bvalid2", {31'd0, BVALID}, 32'd0);
        axi_read(8'h00, rd);
        check("rst_resp_moder", rd, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
